dm_wait_responder: RTL



---
 rtl/mem_pkg.sv | 66 ++++++
 rtl/dm_lane_unit.sv | 47 ++++
 rtl/dm_wait_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-interface encodings and helpers for the MEM stage, control unit
// and pipeline registers.
package mem_pkg;

    // Store size carried on wr_bits (2'b11 falls back to a word store).
    typedef enum logic [1:0] {
        MW_WORD = 2'b00,
        MW_HALF = 2'b01,
        MW_BYTE = 2'b10
    } mem_wr_e;

    // Load type carried on r_bits (unlisted codes fall back to lw).
    typedef enum logic [2:0] {
        MR_LW  = 3'b000,
        MR_LH  = 3'b001,
        MR_LHU = 3'b010,
        MR_LB  = 3'b011,
        MR_LBU = 3'b100
    } mem_rd_e;

    // Responder FSM states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } dm_state_e;

    // Access width after decoding either direction's size field.
    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } acc_size_e;

    function automatic acc_size_e store_size(input logic [1:0] wr_bits);
        acc_size_e sz;
        case (wr_bits)
            MW_HALF: sz = SZ_HALF;
            MW_BYTE: sz = SZ_BYTE;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic acc_size_e load_size(input logic [2:0] r_bits);
        acc_size_e sz;
        case (r_bits)
            MR_LH, MR_LHU: sz = SZ_HALF;
            MR_LB, MR_LBU: sz = SZ_BYTE;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Words need both low address bits clear, halves need bit 0 clear.
    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] byte_off);
        logic bad;
        case (sz)
            SZ_WORD: bad = (byte_off != 2'b00);
            SZ_HALF: bad = byte_off[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane logic for the data memory: store merge, load extraction with
// sign/zero extension, and misalignment detection.
module dm_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  wr_bits,
    input  logic [2:0]  r_bits,
    input  logic        is_store,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    acc_size_e   size;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Decode access width for the active direction and merge store data into the old word.
    always_comb begin
        size       = is_store ? store_size(wr_bits) : load_size(r_bits);
        misalign   = is_misaligned(size, byte_off);
        store_word = old_word;
        case (size)
            SZ_BYTE: store_word[{byte_off, 3'b000} +: 8]   = wdata[7:0];
            SZ_HALF: store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

    // Pick the addressed lane out of the word and extend it to 32 bits.
    always_comb begin
        sel_byte  = old_word[{byte_off, 3'b000} +: 8];
        sel_half  = old_word[{byte_off[1], 4'b0000} +: 16];
        load_data = old_word;
        case (r_bits)
            MR_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            MR_LBU:  load_data = {24'h000000, sel_byte};
            MR_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            MR_LHU:  load_data = {16'h0000, sel_half};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/dm_wait_responder.sv
// MEM-stage data-memory responder: accepts one load/store, holds the pipeline
// for a fixed number of wait states, then completes against a word array.
module dm_wait_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_wr,
    input  logic [1:0]  wr_bits,
    input  logic [2:0]  r_bits,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        mem_stall,
    output logic        misalign
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dm_state_e          state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         wr_bits_q, wr_bits_d;
    logic [2:0]         r_bits_q, r_bits_d;
    logic               is_store_q, is_store_d;
    logic               done_q, done_d;

    logic [31:0]        mem_array [DEPTH];
    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        old_word;
    logic [31:0]        store_word;
    logic [31:0]        load_data;
    logic               lane_misalign;
    logic               mem_we;
    logic               addr_unused;

    // Upper address bits only alias the array, so they are deliberately dropped.
    assign addr_unused = ^addr[31:ADDR_W+2];

    assign word_idx = addr_q[ADDR_W+1:2];
    assign old_word = mem_array[word_idx];

    dm_lane_unit u_lane (
        .old_word   (old_word),
        .wdata      (wdata_q),
        .byte_off   (addr_q[1:0]),
        .wr_bits    (wr_bits_q),
        .r_bits     (r_bits_q),
        .is_store   (is_store_q),
        .store_word (store_word),
        .load_data  (load_data),
        .misalign   (lane_misalign)
    );

    // Next-state logic: latch a request in IDLE, count down wait states, pulse DONE once.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_bits_d  = wr_bits_q;
        r_bits_d   = r_bits_q;
        is_store_d = is_store_q;
        case (state_q)
            S_IDLE: begin
                if (mem_r || mem_wr) begin
                    addr_d     = addr[ADDR_W+1:0];
                    wdata_d    = wdata;
                    wr_bits_d  = wr_bits;
                    r_bits_d   = r_bits;
                    is_store_d = mem_wr;
                    count_d    = WAIT_INIT;
                    state_d    = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                count_d = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                count_d = 4'd0;
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    // FSM and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wr_bits_q  <= 2'd0;
            r_bits_q   <= 3'd0;
            is_store_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_bits_q  <= wr_bits_d;
            r_bits_q   <= r_bits_d;
            is_store_q <= is_store_d;
            done_q     <= done_d;
        end
    end

    // A reset landing on the DONE edge must not let the pending store through.
    assign mem_we = done_q && is_store_q && !lane_misalign && !rst;

    // Word array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[word_idx] <= store_word;
        end
    end

    assign done      = done_q;
    assign misalign  = done_q && lane_misalign;
    assign rdata     = (done_q && !is_store_q && !lane_misalign) ? load_data : 32'd0;
    assign mem_stall = ((state_q == S_IDLE) && (mem_r || mem_wr)) || (state_q == S_WAIT);

endmodule
